muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multi-cycle RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), XLEN-generic.
//  Sits beside the single-cycle ALU in EX. It takes operands via a valid/ready handshake and returns a
//  tagged result via a valid/ready handshake. Radix-2 shift-add multiply and restoring divide run
//  on magnitudes, with sign fix-up. Divide-by-zero and signed overflow take a one-cycle fast path.
// PARAMETERS
//  XLEN   32  operand/result width; power of two, >= 8
//  TAG_W  5   width of pass-through tag (destination register index)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       kill in-flight op (pipeline flush)
//  in_valid   in   1       request valid
//  in_ready   out  1       unit can accept request this cycle
//  in_op      in   3       funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  in_rs1     in   XLEN    operand A (dividend / multiplicand)
//  in_rs2     in   XLEN    operand B (divisor / multiplier)
//  in_tag     in   TAG_W   tag returned with result
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_data   out  XLEN    result
//  out_tag    out  TAG_W   tag of the op that produced out_data
// BEHAVIOUR
//  - States: IDLE, BUSY, DONE. Reset -> IDLE; out_valid=0, out_data=0, out_tag=0, counter=0, accumulators=0.
//  - in_ready = !rst && (IDLE || (DONE && out_ready)); combinational, so back-to-back issue needs no bubble.
//  - Accept = in_valid && in_ready && !flush. On accept: latch op, tag, |rs1|, |rs2| and signs, then go to BUSY.
//  - BUSY: one bit per cycle, counter XLEN-1 down to 0. On the edge where counter==0: apply sign fix-up,
//    register out_data, go to DONE. The first out_valid cycle is exactly XLEN+1 cycles after the accept cycle.
//  - DONE: out_valid=1. out_data and out_tag hold stable until out_valid && out_ready. On that handshake:
//    go to IDLE, or straight to BUSY if a new accept occurs in the same cycle.
//  - Sign rules: MUL/MULH treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned.
//    MULHU and DIVU/REMU treat both as unsigned. The product is 2*XLEN bits. MUL returns [XLEN-1:0];
//    the MULH* ops return [2*XLEN-1:XLEN]. Product sign = sA^sB, negated over the full 2*XLEN.
//  - Division: quotient sign = sA^sB, remainder sign = sA. |dividend| = 2^(XLEN-1) is handled in XLEN bits.
//  - Fast path, decided at accept, goes directly to DONE (out_valid in the cycle after accept):
//      divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//      DIV/REM with rs1==100..0 and rs2==all ones: DIV -> rs1; REM -> 0.
//  - flush: synchronous, highest priority after rst. Next state is IDLE, out_valid=0 next cycle, and the
//    in-flight or pending result is dropped. A request presented while flush is high is not accepted.
//  - rst mid-operation: same as reset. No partial result is ever presented.
//  - in_op/in_rs*/in_tag are sampled only on accept; changes at other times have no effect.
// TESTING
//  1. XLEN=32. MUL 7 x 0xFFFFFFFD -> out_data 0xFFFFFFEB. out_valid first high exactly 33 cycles after
//     the accept cycle; out_tag equals the issued tag.
//  2. MULH 0x80000000,0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFF9,2 -> 0xFFFFFFFD. REM 0xFFFFFFF9,2 -> 0xFFFFFFFF. DIVU 100,7 -> 14. REMU 100,7 -> 2.
//  4. DIVU 5,0 -> 0xFFFFFFFF. REM 5,0 -> 5. DIV 0x80000000,0xFFFFFFFF -> 0x80000000. REM same -> 0.
//     Each of these has out_valid in the cycle after accept.
//  5. Hold out_ready=0 for 10 cycles in DONE: out_data/out_tag stable and in_ready=0. Then out_ready=1
//     with in_valid=1: both handshakes occur in the same cycle, and the next result arrives 33 cycles later.
//  6. Assert flush (and separately rst) in BUSY cycle 10: out_valid never rises for that op,
//     in_ready=1 next cycle, and the following op returns a correct result.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV M-extension unit covering MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
//   It sits beside the single-cycle ALU in EX. Operands arrive through a valid/ready handshake,
//   and the tagged result leaves through another valid/ready handshake.
//   Multiply is a radix-2 shift-add and divide is a restoring divider. Both run on operand
//   magnitudes, and the sign is fixed up on the last step. Divide-by-zero and signed overflow
//   skip the iteration and finish one cycle after accept.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   flush      kills any in-flight or pending result
//   in_valid   request valid
//   in_ready   request can be accepted this cycle (combinational)
//   in_op      funct3 (000 MUL .. 111 REMU)
//   in_rs1     operand A (multiplicand / dividend)
//   in_rs2     operand B (multiplier / divisor)
//   in_tag     tag returned with the result
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   result
//   out_tag    tag of the op that produced out_data
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic [XLEN-1:0]   hi_reg;      // mul: upper product half, div: partial remainder
    logic [XLEN-1:0]   lo_reg;      // mul: multiplier / lower product, div: dividend / quotient
    logic [XLEN-1:0]   b_reg;       // mul: |multiplicand|, div: |divisor|
    logic [2:0]        op_reg;
    logic              sa_reg;
    logic              sb_reg;
    logic [TAG_W-1:0]  tag_reg;

    // ---------------------------------------------------------------
    // Request decode (only meaningful on accept)
    // ---------------------------------------------------------------
    logic              accept;
    logic              a_signed;
    logic              b_signed;
    logic              sa_in;
    logic              sb_in;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              fast_zero;
    logic              fast_ovf;
    logic [XLEN-1:0]   fast_data;

    assign in_ready = !rst && ((state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        if (in_op[2]) begin
            // DIV/REM are signed; DIVU/REMU are not
            a_signed = !in_op[0];
            b_signed = !in_op[0];
        end else begin
            // MUL, MULH: both signed; MULHSU: rs1 only; MULHU: neither
            a_signed = (in_op[1:0] != 2'b11);
            b_signed = !in_op[1];
        end
        sa_in = a_signed && in_rs1[XLEN-1];
        sb_in = b_signed && in_rs2[XLEN-1];
        // The magnitude of the most negative value is still correct when read as unsigned.
        abs_a = sa_in ? -in_rs1 : in_rs1;
        abs_b = sb_in ? -in_rs2 : in_rs2;

        fast_zero = in_op[2] && (in_rs2 == '0);
        fast_ovf  = in_op[2] && !in_op[0] && (in_rs1 == MIN_NEG) && (in_rs2 == '1);
        if (fast_zero) begin
            fast_data = in_op[1] ? in_rs1 : '1;
        end else begin
            fast_data = in_op[1] ? '0 : in_rs1;
        end
    end

    // ---------------------------------------------------------------
    // One iteration step plus the sign fix-up applied on the last step
    // ---------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_qbit;
    logic [XLEN-1:0]   hi_next;
    logic [XLEN-1:0]   lo_next;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_next;

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is set, then shift
        // the {carry, hi, lo} chain right by one. This retires one multiplier bit per cycle.
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        // Restoring divide: shift the next dividend bit into the remainder, then trial-subtract.
        // The difference's top bit is set exactly when the subtraction would go negative.
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        div_qbit  = !div_diff[XLEN];

        if (op_reg[2]) begin
            hi_next = div_qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], div_qbit};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
        end

        prod_mag = {hi_next, lo_next};
        prod_fix = (sa_reg ^ sb_reg) ? -prod_mag : prod_mag;
        quo_fix  = (sa_reg ^ sb_reg) ? -lo_next : lo_next;
        rem_fix  = sa_reg ? -hi_next : hi_next;

        if (op_reg[2]) begin
            result_next = op_reg[1] ? rem_fix : quo_fix;
        end else if (op_reg[1:0] == 2'b00) begin
            result_next = prod_fix[XLEN-1:0];
        end else begin
            result_next = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ---------------------------------------------------------------
    // Control FSM and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            tag_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            state_reg <= S_IDLE;
            out_valid <= 1'b0;
        end else if (accept) begin
            // Accept happens from IDLE, or from DONE in the same cycle as the result handshake.
            op_reg  <= in_op;
            sa_reg  <= sa_in;
            sb_reg  <= sb_in;
            tag_reg <= in_tag;
            hi_reg  <= '0;
            lo_reg  <= in_op[2] ? abs_a : abs_b;
            b_reg   <= in_op[2] ? abs_b : abs_a;
            if (fast_zero || fast_ovf) begin
                state_reg <= S_DONE;
                count_reg <= '0;
                out_valid <= 1'b1;
                out_data  <= fast_data;
                out_tag   <= in_tag;
            end else begin
                state_reg <= S_BUSY;
                count_reg <= CW'(XLEN - 1);
                out_valid <= 1'b0;
            end
        end else begin
            case (state_reg)
                S_BUSY: begin
                    hi_reg <= hi_next;
                    lo_reg <= lo_next;
                    if (count_reg == '0) begin
                        state_reg <= S_DONE;
                        out_valid <= 1'b1;
                        out_data  <= result_next;
                        out_tag   <= tag_reg;
                    end else begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
